unit_phase_sequencer: RTL and testbench
=======================================

UNIT_PHASE_SEQUENCER -- requirements
Module: unit_phase_sequencer

Interface
REQ-001 Parameter NUM_LAYERS, 4, number of unit layers sequenced; SHALL be >= 1.
REQ-002 Parameter SETTLE_CYCLES, 3, cycles each layer step holds its propagate strobe; SHALL be >= 1.
REQ-003 Parameter OSC_DIV, 2, cycles between oscillator toggles; SHALL be >= 1.
REQ-004 clk_in  input  1  sole clock; all logic on rising edge.
REQ-005 rst_in  input  1  synchronous, active-low reset.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_train  input  1  1 = forward then backward pass; 0 = forward only; sampled on acceptance.
REQ-008 cmd_ready  output  1  high only in IDLE.
REQ-009 abort  input  1  cancels the active command.
REQ-010 fd_prop  output  1  forward-propagate strobe to the unit array.
REQ-011 bk_prop  output  1  backward-propagate strobe to the unit array.
REQ-012 oscillator  output  1  free-running toggle shared by all units.
REQ-013 layer_idx  output  max(1,$clog2(NUM_LAYERS))  layer currently being strobed.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse on normal completion.
REQ-016 aborted  output  1  one-cycle pulse when an abort takes effect.

Function
REQ-017 States SHALL be IDLE, FWD, BWD, DONE; encoding from the shared package.
REQ-018 Command accepted on the rising edge where cmd_valid && cmd_ready; cmd_train latched then; cmd_valid while busy is ignored.
REQ-019 IDLE -> FWD on acceptance with layer_idx = 0 and settle counter = 0.
REQ-020 FWD: fd_prop = 1 every cycle; settle counter counts 0..SETTLE_CYCLES-1; at terminal count layer_idx increments and counter clears.
REQ-021 FWD at last layer and terminal count: -> BWD with layer_idx = NUM_LAYERS-1 if latched train = 1, else -> DONE.
REQ-022 BWD: bk_prop = 1 every cycle; layer_idx decrements at each terminal count; at layer 0 terminal count -> DONE.
REQ-023 DONE: done = 1 for exactly one cycle, then -> IDLE; fd_prop = bk_prop = 0.
REQ-024 fd_prop and bk_prop SHALL never be high in the same cycle.
REQ-025 Latency: command accepted at edge t gives fd_prop high cycles t+1 .. t+N*S; done at t+N*S+1 (forward only) or t+2*N*S+1 (train), N = NUM_LAYERS, S = SETTLE_CYCLES.
REQ-026 abort in FWD, BWD or DONE: next state IDLE, strobes low next cycle, aborted = 1 for one cycle, done not asserted.
REQ-027 abort in IDLE SHALL have no effect; simultaneous cmd_valid is accepted normally.
REQ-028 abort on the final step's terminal count wins: no done, aborted pulses.
REQ-029 oscillator toggles every OSC_DIV cycles independent of state; layer_idx counters never wrap outside 0..N-1.

Reset
REQ-030 rst_in low at a rising edge: state IDLE, fd_prop = bk_prop = 0, done = aborted = 0, busy = 0, cmd_ready = 1 after release, layer_idx = 0, oscillator = 0, all counters 0.
REQ-031 Reset mid-command discards the command without done or aborted pulses.

Structure
REQ-032 Package bitnet_seq_pkg SHALL hold the state enum typedef and default values of NUM_LAYERS, SETTLE_CYCLES, OSC_DIV.
REQ-033 Oscillator generation SHALL be a sub-module osc_divider (parameter OSC_DIV, ports clk_in, rst_in, oscillator).

Verification
REQ-034 N=4, S=3, cmd_train=0 accepted at cycle 0 -> fd_prop high cycles 1-12, layer_idx 0,0,0,1,1,1,2,2,2,3,3,3, done at 13, cmd_ready at 14.
REQ-035 Same with cmd_train=1 -> fd_prop cycles 1-12, bk_prop cycles 13-24 with layer_idx 3 down to 0, done at 25.
REQ-036 Abort at cycle 5 of a train command -> strobes low from cycle 6, aborted pulse at 6, no done, next command accepted at 6 or later.
REQ-037 cmd_valid held high through a command -> exactly one acceptance per IDLE visit; abort in IDLE with cmd_valid -> command accepted.
REQ-038 rst_in low at cycle 8 of a command -> all outputs at reset values next cycle, no done; OSC_DIV=2 -> oscillator period 4 cycles from reset.
REQ-039 Assertions: fd_prop && bk_prop never true; done and aborted never both high.

Source files
------------

// File: rtl/unit_phase_sequencer_pkg.sv
// Shared definitions for the unit phase sequencer: state encoding, default
// sizing and a counter-width helper.
package bitnet_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    BWD  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  localparam int DEF_NUM_LAYERS    = 4;
  localparam int DEF_SETTLE_CYCLES = 3;
  localparam int DEF_OSC_DIV       = 2;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/unit_phase_sequencer_if.sv
// Command and strobe bundle between a controller (master) and the sequencer
// (slave).
//
// Handshake: a command transfers on the rising edge where cmd_valid and
// cmd_ready are both high; cmd_train is sampled on that edge only. cmd_ready
// is high only while the sequencer is idle, so cmd_valid while busy is simply
// ignored. abort is a level the sequencer samples every edge while busy.
interface unit_phase_sequencer_if #(
  parameter int LIDX_W = 2
);
  logic              cmd_valid;
  logic              cmd_train;
  logic              cmd_ready;
  logic              abort;
  logic              fd_prop;
  logic              bk_prop;
  logic              oscillator;
  logic [LIDX_W-1:0] layer_idx;
  logic              busy;
  logic              done;
  logic              aborted;

  modport master (
    output cmd_valid, cmd_train, abort,
    input  cmd_ready, fd_prop, bk_prop, oscillator, layer_idx, busy, done, aborted
  );

  modport slave (
    input  cmd_valid, cmd_train, abort,
    output cmd_ready, fd_prop, bk_prop, oscillator, layer_idx, busy, done, aborted
  );
endinterface

// File: rtl/unit_phase_sequencer_osc_divider.sv
// Free-running oscillator: toggles once every OSC_DIV clock cycles, starting
// low out of reset.
module osc_divider
  import bitnet_seq_pkg::*;
#(
  parameter int OSC_DIV = DEF_OSC_DIV
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic oscillator
);

  localparam int CW = cnt_width(OSC_DIV);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      div_cnt    <= '0;
      oscillator <= 1'b0;
    end else if (div_cnt == CW'(OSC_DIV - 1)) begin
      div_cnt    <= '0;
      oscillator <= ~oscillator;
    end else begin
      div_cnt    <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/unit_phase_sequencer.sv
// Walks the unit array layer by layer, holding a forward (and optionally a
// backward) propagate strobe for SETTLE_CYCLES per layer.
module unit_phase_sequencer
  import bitnet_seq_pkg::*;
#(
  parameter int NUM_LAYERS    = DEF_NUM_LAYERS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int OSC_DIV       = DEF_OSC_DIV
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  unit_phase_sequencer_if.slave  bus,
  output seq_state_t             state_dbg
);

  localparam int LW = cnt_width(NUM_LAYERS);
  localparam int SW = cnt_width(SETTLE_CYCLES);

  seq_state_t    state;
  logic [LW-1:0] layer_q;
  logic [SW-1:0] settle_q;
  logic          train_q;
  logic          fd_q;
  logic          bk_q;
  logic          ready_q;
  logic          busy_q;
  logic          done_q;
  logic          aborted_q;

  wire settle_tc = (settle_q == SW'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      layer_q   <= '0;
      settle_q  <= '0;
      train_q   <= 1'b0;
      fd_q      <= 1'b0;
      bk_q      <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      // Abort outranks everything, including the final terminal count.
      if (bus.abort && state != IDLE) begin
        state     <= IDLE;
        layer_q   <= '0;
        settle_q  <= '0;
        fd_q      <= 1'b0;
        bk_q      <= 1'b0;
        ready_q   <= 1'b1;
        busy_q    <= 1'b0;
        aborted_q <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (bus.cmd_valid) begin
              state    <= FWD;
              train_q  <= bus.cmd_train;
              layer_q  <= '0;
              settle_q <= '0;
              fd_q     <= 1'b1;
              ready_q  <= 1'b0;
              busy_q   <= 1'b1;
            end
          end
          FWD: begin
            if (!settle_tc) begin
              settle_q <= settle_q + SW'(1);
            end else begin
              settle_q <= '0;
              if (layer_q != LW'(NUM_LAYERS - 1)) begin
                layer_q <= layer_q + LW'(1);
              end else if (train_q) begin
                state   <= BWD;
                layer_q <= LW'(NUM_LAYERS - 1);
                fd_q    <= 1'b0;
                bk_q    <= 1'b1;
              end else begin
                state   <= DONE;
                layer_q <= '0;
                fd_q    <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          BWD: begin
            if (!settle_tc) begin
              settle_q <= settle_q + SW'(1);
            end else begin
              settle_q <= '0;
              if (layer_q != '0) begin
                layer_q <= layer_q - LW'(1);
              end else begin
                state  <= DONE;
                bk_q   <= 1'b0;
                done_q <= 1'b1;
              end
            end
          end
          DONE: begin
            state   <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
          default: begin
            state   <= IDLE;
            fd_q    <= 1'b0;
            bk_q    <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  osc_divider #(
    .OSC_DIV (OSC_DIV)
  ) u_osc (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .oscillator (bus.oscillator)
  );

  assign bus.cmd_ready = ready_q;
  assign bus.fd_prop   = fd_q;
  assign bus.bk_prop   = bk_q;
  assign bus.layer_idx = layer_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_unit_phase_sequencer.sv
// Directed bench for unit_phase_sequencer: per-cycle vector table for the
// command scenarios plus hand-written reset and oscillator sequences.
module tb_unit_phase_sequencer;
  import bitnet_seq_pkg::*;

  localparam int N_C = 4;
  localparam int S_C = 3;

  logic       clk;
  logic       rst_in;
  seq_state_t state_dbg;
  int         total;
  int         bad;

  unit_phase_sequencer_if #(.LIDX_W(2)) bus_if ();

  unit_phase_sequencer #(
    .NUM_LAYERS    (N_C),
    .SETTLE_CYCLES (S_C),
    .OSC_DIV       (2)
  ) dut (
    .clk_in    (clk),
    .rst_in    (rst_in),
    .bus       (bus_if),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v, t, a;
    logic fd, bk;
    int   li;        // -1: layer index not checked
    logic dn, ab, rdy, bsy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // driver / table builder tasks
  task automatic add(input logic v, t, a, fd, bk, input int li, input logic dn, ab, rdy, bsy);
    vec_t r;
    r.v = v; r.t = t; r.a = a; r.fd = fd; r.bk = bk; r.li = li;
    r.dn = dn; r.ab = ab; r.rdy = rdy; r.bsy = bsy;
    tbl.push_back(r);
  endtask

  task automatic add_idle(input logic v, t, a);
    add(v, t, a, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic add_aborted(input logic v, t, a);
    add(v, t, a, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic add_done(input logic v, a);
    add(v, 1'b0, a, 1'b0, 1'b0, -1, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic add_fwd(input logic v, input int rows, input logic abort_last);
    for (int k = 0; k < rows; k++)
      add(v, 1'b0, abort_last && (k == rows - 1), 1'b1, 1'b0, k / S_C, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic add_bwd(input int rows, input logic abort_last);
    for (int k = 0; k < rows; k++)
      add(1'b0, 1'b0, abort_last && (k == rows - 1), 1'b0, 1'b1, (N_C - 1) - k / S_C, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic drive(input logic v, t, a);
    bus_if.cmd_valid = v;
    bus_if.cmd_train = t;
    bus_if.abort     = a;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " state"},   32'(state_dbg),          32'(IDLE));
    chk({tag, " fd"},      32'(bus_if.fd_prop),     32'd0);
    chk({tag, " bk"},      32'(bus_if.bk_prop),     32'd0);
    chk({tag, " done"},    32'(bus_if.done),        32'd0);
    chk({tag, " aborted"}, 32'(bus_if.aborted),     32'd0);
    chk({tag, " busy"},    32'(bus_if.busy),        32'd0);
    chk({tag, " ready"},   32'(bus_if.cmd_ready),   32'd1);
    chk({tag, " layer"},   32'(bus_if.layer_idx),   32'd0);
    chk({tag, " osc"},     32'(bus_if.oscillator),  32'd0);
  endtask

  // Invariants checked every cycle out of reset.
  always @(negedge clk) begin
    if (rst_in === 1'b1) begin
      if (bus_if.fd_prop === 1'b1 && bus_if.bk_prop === 1'b1) begin
        bad++;
        $display("FAIL strobe_overlap: fd=1 bk=1 want not both");
      end
      if (bus_if.done === 1'b1 && bus_if.aborted === 1'b1) begin
        bad++;
        $display("FAIL done_aborted_overlap: done=1 aborted=1 want not both");
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    drive(1'b0, 1'b0, 1'b0);
    rst_in = 1'b0;

    // Reset values, then oscillator period of 4 from the last reset edge.
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_in = 1'b1;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("osc%0d", i), 32'(bus_if.oscillator), 32'((i / 2) % 2));
    end

    // Forward-only command.
    add_idle(1, 0, 0); add_fwd(0, N_C * S_C, 0); add_done(0, 0); add_idle(0, 0, 0);
    // Train command.
    add_idle(1, 1, 0); add_fwd(0, N_C * S_C, 0); add_bwd(N_C * S_C, 0); add_done(0, 0); add_idle(0, 0, 0);
    // Abort at cycle 5 of a train command, new command accepted in the aborted cycle.
    add_idle(1, 1, 0); add_fwd(0, 5, 1); add_aborted(1, 0, 0);
    add_fwd(0, N_C * S_C, 0); add_done(0, 0); add_idle(0, 0, 0);
    // cmd_valid held high: one acceptance per IDLE visit; abort+valid in IDLE accepted.
    add_idle(1, 0, 0); add_fwd(1, N_C * S_C, 0); add_done(1, 0); add_idle(1, 0, 0);
    add_fwd(0, N_C * S_C, 0); add_done(0, 0); add_idle(1, 0, 1);
    add_fwd(0, N_C * S_C, 0); add_done(0, 0); add_idle(0, 0, 0);
    // Abort on the final terminal count wins over done.
    add_idle(1, 0, 0); add_fwd(0, N_C * S_C, 1); add_aborted(0, 0, 0); add_idle(0, 0, 0);
    // Abort while in DONE.
    add_idle(1, 0, 0); add_fwd(0, N_C * S_C, 0); add_done(0, 1); add_aborted(0, 0, 0); add_idle(0, 0, 0);
    // Abort mid backward pass.
    add_idle(1, 1, 0); add_fwd(0, N_C * S_C, 0); add_bwd(5, 1); add_aborted(0, 0, 0); add_idle(0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      chk($sformatf("row%0d fd", i),      32'(bus_if.fd_prop),   32'(tbl[i].fd));
      chk($sformatf("row%0d bk", i),      32'(bus_if.bk_prop),   32'(tbl[i].bk));
      chk($sformatf("row%0d done", i),    32'(bus_if.done),      32'(tbl[i].dn));
      chk($sformatf("row%0d aborted", i), 32'(bus_if.aborted),   32'(tbl[i].ab));
      chk($sformatf("row%0d ready", i),   32'(bus_if.cmd_ready), 32'(tbl[i].rdy));
      chk($sformatf("row%0d busy", i),    32'(bus_if.busy),      32'(tbl[i].bsy));
      if (tbl[i].li >= 0 && (tbl[i].fd || tbl[i].bk))
        chk($sformatf("row%0d layer", i), 32'(bus_if.layer_idx), 32'(tbl[i].li));
      drive(tbl[i].v, tbl[i].t, tbl[i].a);
    end

    // Reset at cycle 8 of a command discards it silently.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0);
      chk($sformatf("mid c%0d fd", c),    32'(bus_if.fd_prop),   32'd1);
      chk($sformatf("mid c%0d layer", c), 32'(bus_if.layer_idx), 32'((c - 1) / S_C));
    end
    rst_in = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    rst_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk($sformatf("post%0d done", i),    32'(bus_if.done),       32'd0);
      chk($sformatf("post%0d aborted", i), 32'(bus_if.aborted),    32'd0);
      chk($sformatf("post%0d ready", i),   32'(bus_if.cmd_ready),  32'd1);
      chk($sformatf("post%0d osc", i),     32'(bus_if.oscillator), 32'((i / 2) % 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
